fir_mac_sequencer: RTL and testbench

- Time-multiplexed FIR controller that sequences the N-deep 16-bit sample delay line and a single signed multiply-accumulate unit.
- On each accepted input sample it pulses the delay-line shift, then walks tap_sel through taps 0..N-1, one multiply-accumulate per cycle.
- It then rounds and saturates the result to a Q15 output word and presents it on a valid/ready output port.
- Sits between the upstream sample source and downstream consumer; the delay line and coefficient ROM are external and indexed by tap_sel.

---
 rtl/fir_mac_sequencer.sv | 111 +++++++++++
 tb/tb_fir_mac_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR sequencer: one shift, N serial MACs, then a
// rounded and saturated Q15 result on a valid/ready port.
`timescale 1ns/1ps
module fir_mac_sequencer #(
  parameter int N      = 8,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32 + $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            data_in,
  output logic                   shift_en,
  output logic [15:0]            shift_data,
  output logic [$clog2(N)-1:0]   tap_sel,
  input  logic [15:0]            tap_data,
  input  logic [COEF_W-1:0]      coef_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            data_out,
  output logic                   busy
);

  localparam int TW = $clog2(N);
  localparam int PW = 16 + COEF_W;
  localparam logic [TW-1:0] LAST = TW'(N - 1);
  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'(64'd1 << (COEF_W - 2));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [TW-1:0]            r_tap;
  logic                     r_out_valid;
  logic [15:0]              r_data_out;

  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic [15:0]              w_sat;
  logic                     w_accept;

  assign w_prod = $signed(tap_data) * $signed(coef_data);
  assign w_sum  = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  // Round half up, then drop the COEF_W-1 fractional bits
  assign w_rnd  = (w_sum + RND) >>> (COEF_W - 1);

  always_comb begin
    w_sat = w_rnd[15:0];
    if (w_rnd > MAXV)
      w_sat = 16'h7fff;
    else if (w_rnd < MINV)
      w_sat = 16'h8000;
  end

  assign in_ready   = (r_state == S_IDLE);
  assign w_accept   = in_valid & in_ready & rst;
  assign shift_en   = w_accept;
  assign shift_data = data_in;
  assign tap_sel    = r_tap;
  assign out_valid  = r_out_valid;
  assign data_out   = r_data_out;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_tap       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= '0;
            r_tap   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (r_tap == LAST) begin
            r_tap       <= '0;
            r_data_out  <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer with an external delay line,
// coefficient table and a sum-of-products reference model.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;

  localparam int N  = 8;
  localparam int CW = 16;
  localparam int TW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   data_in = '0;
  logic          shift_en;
  logic [15:0]   shift_data;
  logic [TW-1:0] tap_sel;
  logic [15:0]   tap_data;
  logic [CW-1:0] coef_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [15:0]   data_out;
  logic          busy;

  logic [15:0]   dl [N];
  logic [15:0]   coef [N];
  logic [15:0]   hist [$];
  int            exp_q [$];

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  t_acc = -1000;
  bit  have_acc = 0;
  bit  mon_en = 0;
  bit  rand_or = 0;
  bit  or_fixed = 1;

  fir_mac_sequencer #(.N(N), .COEF_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .shift_data (shift_data),
    .tap_sel    (tap_sel),
    .tap_data   (tap_data),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign tap_data  = dl[tap_sel];
  assign coef_data = coef[tap_sel];

  always @(posedge clk) begin
    if (shift_en) begin
      for (int i = N - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= shift_data;
    end
  end

  always @(posedge clk) begin
    #2;
    out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_fixed;
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_out();
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < N; k++)
      s += longint'($signed(hist[k])) * longint'($signed(coef[k]));
    r = (s + (longint'(1) << (CW - 2))) >>> (CW - 1);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Accepting a sample pushes it into the model history and queues
  // the filter output that must eventually appear.
  task automatic send(input logic [15:0] s, output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    in_valid = 1'b1;
    data_in = s;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      waits++;
      if (in_ready) begin
        chk("shift_en_on_accept", shift_en, 1);
        chk("shift_data", shift_data, s);
        hist.push_front(s);
        void'(hist.pop_back());
        exp_q.push_back(model_out());
        t_acc = cyc + 1;
        have_acc = 1;
        ok = 1;
      end else begin
        chk("shift_en_while_busy", shift_en, 0);
      end
      tick();
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      tick();
      i++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (have_acc && cyc >= t_acc && cyc < t_acc + N) begin
        chk("tap_sel_sweep", tap_sel, cyc - t_acc);
        chk("busy_mac", busy, 1);
        chk("in_ready_mac", in_ready, 0);
        chk("shift_en_mac", shift_en, 0);
        chk("out_valid_mac", out_valid, 0);
      end
      if (have_acc && cyc == t_acc + N)
        chk("latency_out_valid", out_valid, 1);
      if (out_valid) begin
        chk("in_ready_out", in_ready, 0);
        chk("shift_en_out", shift_en, 0);
        if (exp_q.size() == 0)
          chk("spurious_out_valid", out_valid, 0);
        else if (out_ready)
          chk("data_out", $signed(data_out), exp_q.pop_front());
      end else if (!(have_acc && cyc >= t_acc && cyc < t_acc + N)) begin
        chk("tap_sel_idle", tap_sel, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [15:0] cap;
    for (int k = 0; k < N; k++) begin
      dl[k] = '0;
      coef[k] = 16'h4000;
      hist.push_back(16'h0000);
    end

    rst = 1'b0;
    in_valid = 1'b1;
    data_in = 16'h4000;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tap_sel", tap_sel, 0);
      tick();
    end
    rst = 1'b1;
    mon_en = 1;

    send(16'h4000, w);
    chk("first_accept_after_release", w, 1);
    for (int i = 0; i < 8; i++) send(16'h0000, w);
    drain();

    for (int k = 0; k < N; k++) coef[k] = 16'h7fff;
    for (int i = 0; i < N; i++) send(16'h7fff, w);
    drain();
    for (int i = 0; i < N; i++) send(16'h8000, w);
    drain();

    for (int k = 0; k < N; k++) coef[k] = 16'h0000;
    coef[0] = 16'h4000;
    send(16'h0001, w);
    drain();
    coef[0] = 16'h3fff;
    send(16'h0001, w);
    drain();

    for (int k = 0; k < N; k++) coef[k] = 16'(k * 16'h0800 + 16'h0100);
    or_fixed = 0;
    send(16'h1234, w);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    chk("bp_out_valid_reached", out_valid, 1);
    cap = data_out;
    in_valid = 1'b1;
    data_in = 16'h0f0f;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_data_out_stable", data_out, cap);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_shift_en", shift_en, 0);
      tick();
    end
    or_fixed = 1;
    send(16'h0f0f, w);
    chk("bp_accept_after_release", w, 2);
    drain();

    send(16'h7abc, w);
    tick();
    tick();
    tick();
    have_acc = 0;
    exp_q.delete();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_tap_sel", tap_sel, 0);
    chk("midrst_in_ready", in_ready, 1);
    tick();
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      chk("midrst_no_out", out_valid, 0);
      tick();
    end
    send(16'h0100, w);
    drain();

    for (int blk = 0; blk < 3; blk++) begin
      for (int k = 0; k < N; k++) coef[k] = 16'($urandom_range(0, 65535));
      rand_or = 1;
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send(16'($urandom_range(0, 65535)), w);
      end
      rand_or = 0;
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
